// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
//   Shared definitions for the memory access controller and its wait timer:
//   FSM state encoding, transaction owner and operation encodings, the
//   default timeout/counter sizing, and the Moore output decode used by the
//   top level to build its registered outputs.
package mem_ctrl_pkg;

  // Default number of WAIT cycles tolerated without mem_ready.
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  localparam int DEFAULT_CNT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  typedef struct packed {
    logic mar_en;
    logic mdr_en;
    logic mdr_read;
    logic mem_rd;
    logic mem_wr;
    logic gnt_fetch;
    logic gnt_data;
    logic busy;
    logic done;
    logic err;
  } ctrl_out_t;

  // Moore decode of one controller state. The top level feeds this with the
  // next-state values so the decoded outputs can be registered and still
  // line up with the state they belong to.
  function automatic ctrl_out_t decode_outputs(input state_t st,
                                               input owner_t own,
                                               input op_t    op,
                                               input logic   err_flag);
    ctrl_out_t o;
    o = '0;
    if (st != ST_IDLE) begin
      o.busy      = 1'b1;
      o.gnt_fetch = (own == OWN_FETCH);
      o.gnt_data  = (own == OWN_DATA);
    end
    case (st)
      ST_ADDR: begin
        o.mar_en = 1'b1;
        // A store captures its data from the bus alongside the address.
        if (op == OP_WR) begin
          o.mdr_en   = 1'b1;
          o.mdr_read = 1'b0;
        end
      end
      ST_WAIT: begin
        o.mem_rd = (op == OP_RD);
        o.mem_wr = (op == OP_WR);
      end
      ST_LATCH: begin
        o.mem_rd   = 1'b1;
        o.mdr_en   = 1'b1;
        o.mdr_read = 1'b1;
      end
      ST_DONE: begin
        o.done = 1'b1;
        o.err  = err_flag;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer
//   Counts WAIT cycles for the memory access controller and flags the last
//   cycle allowed before a timeout.
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-high reset, clears the count
//   sync_clr in   synchronous clear (takes priority over inc)
//   inc      in   increment enable
//   tc       out  count has reached TIMEOUT_CYCLES-1
module wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic clr,
  input  logic sync_clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VALUE);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences memory transactions through the MAR/MDR pair and arbitrates
//   the single memory port between the instruction-fetch requester and the
//   data (load/store) requester. Priority in IDLE: store > load > fetch.
//   Every output is registered (Moore); no input reaches an output without
//   passing through a flop.
// Ports:
//   clk, clr                     clock / async active-high reset
//   fetch_req, data_rd_req,
//   data_wr_req                  level requests, held until done
//   mem_ready                    memory handshake, only looked at in WAIT
//   mar_en, mdr_en, mdr_read     MAR load, MDR load, MDR source (1 = memory)
//   mem_rd, mem_wr               memory strobes
//   gnt_fetch, gnt_data          owner of the current transaction
//   busy, done, err              in progress / completion pulse / timeout
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic clr,
  input  logic fetch_req,
  input  logic data_rd_req,
  input  logic data_wr_req,
  input  logic mem_ready,
  output logic mar_en,
  output logic mdr_en,
  output logic mdr_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic gnt_fetch,
  output logic gnt_data,
  output logic busy,
  output logic done,
  output logic err
);

  state_t    state_q, state_d;
  owner_t    owner_q, owner_d;
  op_t       op_q, op_d;
  logic      err_q, err_d;
  ctrl_out_t out_q, out_d;

  logic tmr_clr;
  logic tmr_inc;
  logic tmr_tc;

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .clr     (clr),
    .sync_clr(tmr_clr),
    .inc     (tmr_inc),
    .tc      (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    err_d   = err_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (data_wr_req) begin
          state_d = ST_ADDR;
          owner_d = OWN_DATA;
          op_d    = OP_WR;
        end else if (data_rd_req) begin
          state_d = ST_ADDR;
          owner_d = OWN_DATA;
          op_d    = OP_RD;
        end else if (fetch_req) begin
          state_d = ST_ADDR;
          owner_d = OWN_FETCH;
          op_d    = OP_RD;
        end
      end
      ST_ADDR: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d = (op_q == OP_RD) ? ST_LATCH : ST_DONE;
        end else if (tmr_tc) begin
          // Timed out: skip LATCH so the MDR keeps its previous contents.
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Decoding the next state lets the registered outputs appear in the
    // same cycle as the state they describe.
    out_d = decode_outputs(state_d, owner_d, op_d, err_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_FETCH;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign mar_en    = out_q.mar_en;
  assign mdr_en    = out_q.mdr_en;
  assign mdr_read  = out_q.mdr_read;
  assign mem_rd    = out_q.mem_rd;
  assign mem_wr    = out_q.mem_wr;
  assign gnt_fetch = out_q.gnt_fetch;
  assign gnt_data  = out_q.gnt_data;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign err       = out_q.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Scoreboard bench for mem_access_ctrl built with a 4-cycle timeout.
//   The stimulus process queues the hand-computed shape of each expected
//   transaction (per-cycle masks of MAR/MDR/strobe activity, done cycle,
//   owner, err, idle gap). A monitor records what the DUT actually does
//   from the first busy cycle and compares on every done pulse. A reactive
//   memory model raises mem_ready after a programmed number of WAIT cycles.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic clk         = 1'b0;
  logic clr         = 1'b1;
  logic fetch_req   = 1'b0;
  logic data_rd_req = 1'b0;
  logic data_wr_req = 1'b0;
  logic mem_ready   = 1'b0;
  logic mar_en, mdr_en, mdr_read, mem_rd, mem_wr;
  logic gnt_fetch, gnt_data, busy, done, err;
  logic [9:0] outs;

  int n_checks = 0;
  int n_pass   = 0;

  int ready_delay = 0;
  bit spurious    = 1'b0;
  int wait_seen   = 0;

  typedef struct {
    bit          gnt_fetch;
    bit          err;
    logic [31:0] mar_m;
    logic [31:0] capt_m;
    logic [31:0] rd_m;
    logic [31:0] wr_m;
    logic [31:0] latch_m;
    int          done_cyc;
    int          gap;
  } exp_t;

  exp_t exp_q[$];

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .fetch_req  (fetch_req),
    .data_rd_req(data_rd_req),
    .data_wr_req(data_wr_req),
    .mem_ready  (mem_ready),
    .mar_en     (mar_en),
    .mdr_en     (mdr_en),
    .mdr_read   (mdr_read),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .gnt_fetch  (gnt_fetch),
    .gnt_data   (gnt_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  assign outs = {mar_en, mdr_en, mdr_read, mem_rd, mem_wr,
                 gnt_fetch, gnt_data, busy, done, err};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic applyStimulus(input logic f, input logic r, input logic w);
    fetch_req   = f;
    data_rd_req = r;
    data_wr_req = w;
  endtask

  task automatic pushExp(input bit gf, input bit e, input logic [31:0] mar_m,
                         input logic [31:0] capt_m, input logic [31:0] rd_m,
                         input logic [31:0] wr_m, input logic [31:0] latch_m,
                         input int done_cyc, input int gap);
    exp_t x;
    x.gnt_fetch = gf;   x.err     = e;
    x.mar_m     = mar_m; x.capt_m  = capt_m;
    x.rd_m      = rd_m;  x.wr_m    = wr_m;
    x.latch_m   = latch_m;
    x.done_cyc  = done_cyc;
    x.gap       = gap;
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for a done pulse; returns on the negedge where it is seen.
  task automatic waitDone();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("done_wait_expired", 32'(done), 32'd1);
  endtask

  task automatic runSingle(input logic f, input logic r, input logic w,
                           input int delay, input bit spur);
    ready_delay = delay;
    spurious    = spur;
    applyStimulus(f, r, w);
    waitDone();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    spurious = 1'b0;
  endtask

  // Reactive memory: mem_ready rises in the (delay+1)-th WAIT cycle;
  // delay < 0 means the memory never answers.
  always @(negedge clk) begin
    if (clr || !busy) wait_seen = 0;
    if (!clr && busy && (mem_rd || mem_wr) && !(mdr_en && mdr_read)) begin
      wait_seen++;
      mem_ready = (ready_delay >= 0) && (wait_seen > ready_delay);
    end else begin
      mem_ready = spurious && !clr && (!busy || mar_en);
    end
  end

  // Monitor: record the shape of each transaction, compare on done.
  bit          trk      = 1'b0;
  int          cyc      = 0;
  int          idle_gap = 0;
  int          last_gap = 0;
  logic [31:0] m_mar, m_capt, m_rd, m_wr, m_latch, m_gf, m_gd;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] full;
    if (clr) begin
      trk      = 1'b0;
      idle_gap = 0;
    end else if (!busy) begin
      checkOutput("idle_outputs_zero", 32'(outs), 32'd0);
      if (trk) begin
        checkOutput("busy_dropped_without_done", 32'(busy), 32'd1);
        trk = 1'b0;
      end
      idle_gap++;
    end else begin
      checkOutput("one_grant", 32'(gnt_fetch) + 32'(gnt_data), 32'd1);
      if (!done) checkOutput("err_outside_done", 32'(err), 32'd0);
      if (!trk) begin
        trk      = 1'b1;
        cyc      = 0;
        last_gap = idle_gap;
        m_mar = '0; m_capt = '0; m_rd = '0; m_wr = '0;
        m_latch = '0; m_gf = '0; m_gd = '0;
      end
      cyc++;
      if (cyc < 32) begin
        if (mar_en)              m_mar[cyc]   = 1'b1;
        if (mdr_en && !mdr_read) m_capt[cyc]  = 1'b1;
        if (mdr_en && mdr_read)  m_latch[cyc] = 1'b1;
        if (mem_rd)              m_rd[cyc]    = 1'b1;
        if (mem_wr)              m_wr[cyc]    = 1'b1;
        if (gnt_fetch)           m_gf[cyc]    = 1'b1;
        if (gnt_data)            m_gd[cyc]    = 1'b1;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          e    = exp_q.pop_front();
          full = (32'd1 << (e.done_cyc + 1)) - 32'd2;
          checkOutput("done_cycle",    32'(cyc),     32'(e.done_cyc));
          checkOutput("err",           32'(err),     32'(e.err));
          checkOutput("mar_en_cycles", m_mar,        e.mar_m);
          checkOutput("mdr_bus_capt",  m_capt,       e.capt_m);
          checkOutput("mdr_mem_latch", m_latch,      e.latch_m);
          checkOutput("mem_rd_cycles", m_rd,         e.rd_m);
          checkOutput("mem_wr_cycles", m_wr,         e.wr_m);
          checkOutput("gnt_fetch",     m_gf,         e.gnt_fetch ? full : 32'd0);
          checkOutput("gnt_data",      m_gd,         e.gnt_fetch ? 32'd0 : full);
          if (e.gap >= 0) checkOutput("idle_gap", 32'(last_gap), 32'(e.gap));
        end
        trk      = 1'b0;
        idle_gap = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: everything low while clr is held.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 32'(outs), 32'd0);
    clr = 1'b0;
    @(negedge clk);

    // Fetch, memory ready in the first WAIT cycle.
    pushExp(1'b1, 1'b0, 32'h2, 32'h0, 32'hC, 32'h0, 32'h8, 4, -1);
    runSingle(1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Store with three extra WAIT cycles.
    pushExp(1'b0, 1'b0, 32'h2, 32'h2, 32'h0, 32'h3C, 32'h0, 6, -1);
    runSingle(1'b0, 1'b0, 1'b1, 3, 1'b0);

    // All three requesters at once: store, then load, then fetch.
    ready_delay = 0;
    pushExp(1'b0, 1'b0, 32'h2, 32'h2, 32'h0, 32'h4, 32'h0, 3, -1);
    pushExp(1'b0, 1'b0, 32'h2, 32'h0, 32'hC, 32'h0, 32'h8, 4, 1);
    pushExp(1'b1, 1'b0, 32'h2, 32'h0, 32'hC, 32'h0, 32'h8, 4, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitDone();
    data_wr_req = 1'b0;
    waitDone();
    data_rd_req = 1'b0;
    waitDone();
    fetch_req = 1'b0;
    @(negedge clk);

    // Load that never gets mem_ready: four WAIT cycles, then err.
    pushExp(1'b0, 1'b1, 32'h2, 32'h0, 32'h3C, 32'h0, 32'h0, 6, -1);
    runSingle(1'b0, 1'b1, 1'b0, -1, 1'b0);

    // Next transaction must report err=0 again.
    pushExp(1'b0, 1'b0, 32'h2, 32'h2, 32'h0, 32'hC, 32'h0, 4, -1);
    runSingle(1'b0, 1'b0, 1'b1, 1, 1'b0);

    // mem_ready offered in IDLE and ADDR only is ignored.
    pushExp(1'b0, 1'b0, 32'h2, 32'h0, 32'h3C, 32'h0, 32'h20, 6, -1);
    runSingle(1'b0, 1'b1, 1'b0, 2, 1'b1);

    // clr in the WAIT of a fetch: outputs drop at once, no done pulse,
    // then a fresh fetch starts on the first edge after release.
    ready_delay = -1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) break;
    end
    checkOutput("clr_reached_wait", 32'(mem_rd), 32'd1);
    #2 clr = 1'b1;
    #1 checkOutput("clr_async_outputs", 32'(outs), 32'd0);
    pushExp(1'b1, 1'b0, 32'h2, 32'h0, 32'hC, 32'h0, 32'h8, 4, -1);
    ready_delay = 0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1 checkOutput("clr_restart_mar", 32'(mar_en), 32'd1);
    waitDone();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
